hazard_dest_pipe: RTL and testbench

Tracks register-destination metadata through the EX, EX/MEM and MEM/WB pipeline registers of the 16-register datapath. Produces the EX-stage source numbers and the EX/MEM and MEM/WB destination numbers consumed by the forwarding unit. Also detects load-use hazards, inserts bubbles, applies branch flushes and freezes on memory wait.

---
 rtl/hazard_dest_pipe.sv | 101 ++++++++++
 tb/tb_hazard_dest_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_dest_pipe.sv
// Destination/source metadata pipe (EX, EX/MEM, MEM/WB) with load-use stall,
// branch flush, memory-wait freeze and a saturating stall counter. Optional: ZERO_REG_EN.
module hazard_dest_pipe #(
  parameter int AW = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rt_used,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  input  logic          mem_hold,
  output logic          stall,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] em_rd,
  output logic          em_regwrite,
  output logic [AW-1:0] mw_rd,
  output logic          mw_regwrite,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          memread;
  } ex_t;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          regwrite;
  } wb_t;

  ex_t ex_q, id_cap;
  wb_t em_q, mw_q;
  logic pending_flush, flush_eff, rd_match, rd_ok, hz;

  always_comb begin
    id_cap = '0;
    if (id_valid) begin
      id_cap.valid    = 1'b1;
      id_cap.rs       = id_rs;
      id_cap.rt       = id_rt;
      id_cap.rd       = id_rd;
      id_cap.memread  = id_memread;
`ifdef ZERO_REG_EN
      id_cap.regwrite = id_regwrite & (id_rd != '0);
`else
      id_cap.regwrite = id_regwrite;
`endif
    end
  end

  assign flush_eff = flush | pending_flush;
  assign rd_match  = (ex_q.rd == id_rs) | (id_rt_used & (ex_q.rd == id_rt));
`ifdef ZERO_REG_EN
  assign rd_ok     = (ex_q.rd != '0);
`else
  assign rd_ok     = 1'b1;
`endif
  assign hz    = id_valid & ex_q.valid & ex_q.memread & ex_q.regwrite & rd_match & rd_ok;
  assign stall = hz & ~flush_eff & ~mem_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      em_q          <= '0;
      mw_q          <= '0;
      pending_flush <= 1'b0;
    end else if (mem_hold) begin
      // frozen; remember a branch kill so it lands once memory releases
      if (flush) pending_flush <= 1'b1;
    end else begin
      pending_flush <= 1'b0;
      em_q          <= '{rd: ex_q.rd, regwrite: ex_q.regwrite};
      mw_q          <= em_q;
      ex_q          <= (flush_eff | hz) ? '0 : id_cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
  end

  assign ex_rs       = ex_q.rs;
  assign ex_rt       = ex_q.rt;
  assign em_rd       = em_q.rd;
  assign em_regwrite = em_q.regwrite;
  assign mw_rd       = mw_q.rd;
  assign mw_regwrite = mw_q.regwrite;

endmodule

// File: tb/tb_hazard_dest_pipe.sv
// Scoreboard bench for hazard_dest_pipe: driver queues hand-computed per-cycle
// expectations, monitor pops and compares on the falling edge.
module tb_hazard_dest_pipe;
  localparam int AW = 4;
  localparam int CW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid = 0, id_rt_used = 0, id_regwrite = 0, id_memread = 0, flush = 0, mem_hold = 0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic stall, em_regwrite, mw_regwrite;
  logic [AW-1:0] ex_rs, ex_rt, em_rd, mw_rd;
  logic [CW-1:0] stall_cnt;

  hazard_dest_pipe #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .mem_hold(mem_hold), .stall(stall),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .em_rd(em_rd), .em_regwrite(em_regwrite),
    .mw_rd(mw_rd), .mw_regwrite(mw_regwrite), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic          st;
    logic [AW-1:0] ers, ert, emr;
    logic          emw;
    logic [AW-1:0] mwr;
    logic          mww;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc_no = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc_no, act, req);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic drv(input logic v, input logic [AW-1:0] rs, rt, input logic rtu,
                     input logic [AW-1:0] rd, input logic rw, mr, fl, hd);
    @(posedge clk); #1;
    cyc_no++;
    id_valid = v; id_rs = rs; id_rt = rt; id_rt_used = rtu; id_rd = rd;
    id_regwrite = rw; id_memread = mr; flush = fl; mem_hold = hd;
  endtask

  task automatic idle(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic ex(input logic st, input logic [AW-1:0] ers, ert, emr, input logic emw,
                    input logic [AW-1:0] mwr, input logic mww, input logic [CW-1:0] cnt);
    exp_t e;
    e = '{st: st, ers: ers, ert: ert, emr: emr, emw: emw, mwr: mwr, mww: mww, cnt: cnt};
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall",       int'(stall),       int'(e.st));
        chk("ex_rs",       int'(ex_rs),       int'(e.ers));
        chk("ex_rt",       int'(ex_rt),       int'(e.ert));
        chk("em_rd",       int'(em_rd),       int'(e.emr));
        chk("em_regwrite", int'(em_regwrite), int'(e.emw));
        chk("mw_rd",       int'(mw_rd),       int'(e.mwr));
        chk("mw_regwrite", int'(mw_regwrite), int'(e.mww));
        chk("stall_cnt",   int'(stall_cnt),   int'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int wait_cyc;
    logic [CW-1:0] c;
    #2 rst_n = 1'b1;

    // load-use on rs
    drv(1, 1, 0, 0, 5, 1, 1, 0, 0);  ex(0, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 5, 2, 1, 6, 1, 0, 0, 0);  ex(1, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 5, 2, 1, 6, 1, 0, 0, 0);  ex(0, 0, 0, 5, 1, 0, 0, 1);
    idle();                          ex(0, 5, 2, 0, 0, 5, 1, 1);
    idle();                          ex(0, 0, 0, 6, 1, 0, 0, 1);
    idle();                          ex(0, 0, 0, 0, 0, 6, 1, 1);

    // rt match ignored unless rt is read
    drv(1, 1, 0, 0, 5, 1, 1, 0, 0);  ex(0, 0, 0, 0, 0, 0, 0, 1);
    drv(1, 3, 5, 0, 7, 1, 0, 0, 0);  ex(0, 1, 0, 0, 0, 0, 0, 1);
    idle();                          ex(0, 3, 5, 5, 1, 0, 0, 1);
    drv(1, 1, 0, 0, 5, 1, 1, 0, 0);  ex(0, 0, 0, 7, 1, 5, 1, 1);
    drv(1, 3, 5, 1, 7, 1, 0, 0, 0);  ex(1, 1, 0, 0, 0, 7, 1, 1);
    drv(1, 3, 5, 1, 7, 1, 0, 0, 0);  ex(0, 0, 0, 5, 1, 0, 0, 2);
    idle();                          ex(0, 3, 5, 0, 0, 5, 1, 2);

    // memory hold with a flush in the middle; hazard masked by hold then by pending flush
    drv(1, 4, 6, 1, 8, 1, 1, 0, 0);  ex(0, 0, 0, 7, 1, 0, 0, 2);
    drv(1, 8, 10, 1, 11, 1, 0, 0, 1); ex(0, 4, 6, 0, 0, 7, 1, 2);
    drv(1, 8, 10, 1, 11, 1, 0, 1, 1); ex(0, 4, 6, 0, 0, 7, 1, 2);
    drv(1, 8, 10, 1, 11, 1, 0, 0, 1); ex(0, 4, 6, 0, 0, 7, 1, 2);
    drv(1, 8, 10, 1, 11, 1, 0, 0, 0); ex(0, 4, 6, 0, 0, 7, 1, 2);
    idle();                          ex(0, 0, 0, 8, 1, 0, 0, 2);
    drv(1, 9, 10, 1, 11, 1, 0, 0, 0); ex(0, 0, 0, 0, 0, 8, 1, 2);
    idle();                          ex(0, 9, 10, 0, 0, 0, 0, 2);

    // flush beats hazard
    drv(1, 1, 0, 0, 5, 1, 1, 0, 0);  ex(0, 0, 0, 11, 1, 0, 0, 2);
    drv(1, 5, 2, 1, 6, 1, 0, 1, 0);  ex(0, 1, 0, 0, 0, 11, 1, 2);
    idle();                          ex(0, 0, 0, 5, 1, 0, 0, 2);

    // self-dependent load chain: stall every other cycle, counter saturates at 15
    drv(1, 5, 0, 0, 5, 1, 1, 0, 0);  ex(0, 0, 0, 0, 0, 5, 1, 2);
    for (int i = 0; i < 20; i++) begin
      c = (2 + i > 15) ? 4'd15 : CW'(2 + i);
      drv(1, 5, 0, 0, 5, 1, 1, 0, 0);
      if (i == 0) ex(1, 5, 0, 0, 0, 0, 0, c);
      else        ex(1, 5, 0, 0, 0, 5, 1, c);
      c = (3 + i > 15) ? 4'd15 : CW'(3 + i);
      drv(1, 5, 0, 0, 5, 1, 1, 0, 0);
      ex(0, 0, 0, 5, 1, 0, 0, c);
    end
    idle();                          ex(0, 5, 0, 0, 0, 5, 1, 15);
    idle();                          ex(0, 0, 0, 5, 1, 0, 0, 15);

    // async reset mid-stream while stalling
    drv(1, 5, 0, 0, 5, 1, 1, 0, 0);
    drv(1, 5, 0, 0, 5, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_ex_rs", int'(ex_rs), 0);
    chk("rst_em", int'({em_rd, em_regwrite}), 0);
    chk("rst_mw", int'({mw_rd, mw_regwrite}), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;                    ex(0, 0, 0, 0, 0, 0, 0, 0);

    // load to r0 followed by a read of r0
    drv(1, 1, 0, 0, 0, 1, 1, 0, 0);  ex(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ZERO_REG_EN
    drv(1, 0, 2, 1, 6, 1, 0, 0, 0);  ex(0, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 2, 1, 6, 1, 0, 0, 0);  ex(0, 0, 2, 0, 0, 0, 0, 0);
    idle();                          ex(0, 0, 2, 6, 1, 0, 0, 0);
`else
    drv(1, 0, 2, 1, 6, 1, 0, 0, 0);  ex(1, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 2, 1, 6, 1, 0, 0, 0);  ex(0, 0, 0, 0, 1, 0, 0, 1);
    idle();                          ex(0, 0, 2, 0, 0, 0, 1, 1);
`endif

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() != 0) chk("drain", q.size(), 0);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
